// File: rtl/axis_fifo_pkt.sv
// axis_fifo_pkt: single-clock AXI-stream FIFO storing {tlast, tdata}, optional store-and-forward on tlast.
// Latency: a beat written on edge N is presented in cycle N+1 (cut-through) or the cycle after its frame's tlast is written (packet mode).
// Backpressure: s_axis_tready is registered and low whenever the FIFO will be full; an m_axis_tready stall holds the output entry.
// Ports: clk/rst (async active-high); s_axis_* slave stream in; m_axis_* master stream out;
//        level = stored entries (0..DEPTH); pkt_count = stored complete frames (0..DEPTH).
module axis_fifo_pkt #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 4,
    parameter int PACKET_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [DEPTH_LOG2:0]   level,
    output logic [DEPTH_LOG2:0]   pkt_count
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int PTR_W = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    // Storage is deliberately not reset; level/pointers alone define what is valid.
    logic [DATA_WIDTH:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             forward;

    logic             wr_en;
    logic             rd_en;
    logic             pkt_in;
    logic             pkt_out;
    logic [CNT_W-1:0] level_nxt;
    logic [CNT_W-1:0] pkt_nxt;
    logic             forward_nxt;
    logic             tvalid_nxt;
    logic             tready_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign wr_en   = s_axis_tvalid & s_axis_tready;
    assign rd_en   = m_axis_tvalid & m_axis_tready;
    assign pkt_in  = wr_en & s_axis_tlast;
    assign pkt_out = rd_en & m_axis_tlast;

    always_comb begin
        level_nxt = level;
        if (wr_en && !rd_en) begin
            level_nxt = level + CNT_ONE;
        end else if (!wr_en && rd_en) begin
            level_nxt = level - CNT_ONE;
        end

        pkt_nxt = pkt_count;
        if (pkt_in && !pkt_out) begin
            pkt_nxt = pkt_count + CNT_ONE;
        end else if (!pkt_in && pkt_out) begin
            pkt_nxt = pkt_count - CNT_ONE;
        end

        // A beat leaving while no complete frame is stored can only be the
        // head of a frame that overflowed the FIFO: keep streaming it out
        // until its tlast, otherwise the FIFO would deadlock waiting for a
        // tlast that cannot fit.
        forward_nxt = forward;
        if (rd_en) begin
            if (m_axis_tlast) begin
                forward_nxt = 1'b0;
            end else if (pkt_count == '0) begin
                forward_nxt = 1'b1;
            end
        end

        if (PACKET_MODE != 0) begin
            tvalid_nxt = (level_nxt != '0) &&
                         ((pkt_nxt != '0) || (level_nxt == DEPTH_CNT) || forward_nxt);
        end else begin
            tvalid_nxt = (level_nxt != '0);
        end

        // Registered ready: looking at the next level means a full FIFO is
        // never offered a slot, at the cost of one cycle of low ready after
        // a read from full.
        tready_nxt = (level_nxt < DEPTH_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            pkt_count     <= '0;
            forward       <= 1'b0;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            level         <= level_nxt;
            pkt_count     <= pkt_nxt;
            forward       <= forward_nxt;
            s_axis_tready <= tready_nxt;
            m_axis_tvalid <= tvalid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    // The entry at rd_ptr cannot be overwritten while it is presented:
    // writes only land there when the FIFO is empty, and then tvalid is low.
    assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr];

endmodule

// File: tb/tb_axis_fifo_pkt.sv
module tb_axis_fifo_pkt;
    localparam int NDUT = 3;  // 0: cut-through depth 4, 1: packet depth 8, 2: packet depth 4

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NDUT-1:0]         s_tvalid;
    logic [NDUT-1:0]         s_tready;
    logic [NDUT-1:0][31:0]   s_tdata;
    logic [NDUT-1:0]         s_tlast;
    logic [NDUT-1:0]         m_tvalid;
    logic [NDUT-1:0]         m_tready;
    logic [NDUT-1:0][31:0]   m_tdata;
    logic [NDUT-1:0]         m_tlast;
    logic [NDUT-1:0][4:0]    level;
    logic [NDUT-1:0][4:0]    pkt;
    logic [NDUT-1:0]         fix_rdy;
    logic [NDUT-1:0]         rnd_rdy;
    logic [NDUT-1:0]         rnd_bit;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int DL = (g == 1) ? 3 : 2;
        localparam int PM = (g == 0) ? 0 : 1;
        logic [DL:0] lvl_w;
        logic [DL:0] pkt_w;
        axis_fifo_pkt #(.DATA_WIDTH(32), .DEPTH_LOG2(DL), .PACKET_MODE(PM)) u_dut (
            .clk           (clk),
            .rst           (rst),
            .s_axis_tvalid (s_tvalid[g]),
            .s_axis_tready (s_tready[g]),
            .s_axis_tdata  (s_tdata[g]),
            .s_axis_tlast  (s_tlast[g]),
            .m_axis_tvalid (m_tvalid[g]),
            .m_axis_tready (m_tready[g]),
            .m_axis_tdata  (m_tdata[g]),
            .m_axis_tlast  (m_tlast[g]),
            .level         (lvl_w),
            .pkt_count     (pkt_w)
        );
        assign level[g]    = 5'(lvl_w);
        assign pkt[g]      = 5'(pkt_w);
        assign m_tready[g] = rnd_rdy[g] ? rnd_bit[g] : fix_rdy[g];
    end

    int n_chk = 0;
    int n_err = 0;
    int out_cnt [NDUT];

    logic [32:0] q0 [$];
    logic [32:0] q1 [$];
    logic [32:0] q2 [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int d, input logic [32:0] v);
        case (d)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    function automatic logic [32:0] qpop(input int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qclear(input int d);
        case (d)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    // Output monitor: pops the scoreboard on every output handshake, checks
    // hold-during-stall and the level bound.
    logic [NDUT-1:0]       prev_stall;
    logic [NDUT-1:0][32:0] prev_dat;

    task automatic monitor_one(input int d);
        logic [32:0] act;
        logic [32:0] exp;
        int dep;
        dep = (d == 1) ? 8 : 4;
        if (rst) begin
            qclear(d);
            prev_stall[d] = 1'b0;
            return;
        end
        act = {m_tlast[d], m_tdata[d]};
        if (prev_stall[d]) begin
            check($sformatf("d%0d_stall_vld", d), 64'(m_tvalid[d]), 64'd1);
            check($sformatf("d%0d_stall_dat", d), 64'(act), 64'(prev_dat[d]));
        end
        check($sformatf("d%0d_level_max", d), 64'(int'(level[d]) <= dep), 64'd1);
        if (m_tvalid[d] && m_tready[d]) begin
            if (qsize(d) == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL d%0d_unexpected_beat: got 0x%0h expected none", d, act);
            end else begin
                exp = qpop(d);
                check($sformatf("d%0d_out_beat", d), 64'(act), 64'(exp));
            end
            out_cnt[d]++;
        end
        prev_stall[d] = m_tvalid[d] & ~m_tready[d];
        prev_dat[d]   = act;
    endtask

    initial begin
        prev_stall = '0;
        prev_dat   = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) monitor_one(d);
        end
    end

    initial begin
        rnd_bit = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < NDUT; d++) rnd_bit[d] = 1'($urandom_range(1));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Offers one beat; returns at posedge+1 of the accepting edge, valid left high.
    task automatic send(input int d, input logic [31:0] dat, input logic last, output int waits);
        logic acc;
        waits       = 0;
        s_tvalid[d] = 1'b1;
        s_tdata[d]  = dat;
        s_tlast[d]  = last;
        forever begin
            @(negedge clk);
            acc = s_tready[d];
            if (acc) push(d, {last, dat});
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
            if (waits > 500) begin
                n_chk++;
                n_err++;
                $display("FAIL d%0d_send_timeout: got no ready expected ready within 500 cycles", d);
                break;
            end
        end
    endtask

    task automatic idle(input int d);
        s_tvalid[d] = 1'b0;
        s_tlast[d]  = 1'b0;
    endtask

    task automatic drain(input int d, input string name);
        int t;
        t = 0;
        while ((qsize(d) != 0 || m_tvalid[d]) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check(name, 64'(qsize(d)), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_stream(input int d, input int nbeats, input int maxlen);
        int sent;
        int w;
        sent = 0;
        while (sent < nbeats) begin
            int len;
            len = $urandom_range(maxlen, 1);
            if (len > nbeats - sent) len = nbeats - sent;
            for (int i = 0; i < len; i++) begin
                while ($urandom_range(1) == 0) begin
                    idle(d);
                    @(posedge clk);
                    #1;
                end
                send(d, $urandom(), (i == len - 1), w);
            end
            sent += len;
        end
        idle(d);
    endtask

    initial begin
        int w;
        int base;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        fix_rdy  = '0;
        rnd_rdy  = '0;
        for (int d = 0; d < NDUT; d++) out_cnt[d] = 0;

        // Reset state
        #12;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d_rst_tready", d), 64'(s_tready[d]), 64'd0);
            check($sformatf("d%0d_rst_tvalid", d), 64'(m_tvalid[d]), 64'd0);
            check($sformatf("d%0d_rst_level", d), 64'(level[d]), 64'd0);
            check($sformatf("d%0d_rst_pkt", d), 64'(pkt[d]), 64'd0);
        end
        #10 rst = 1'b0;
        #1 check("rel_tready_before_edge", 64'(s_tready[0]), 64'd0);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d_rel_tready", d), 64'(s_tready[d]), 64'd1);
            check($sformatf("d%0d_rel_tvalid", d), 64'(m_tvalid[d]), 64'd0);
        end
        @(posedge clk);
        #1;

        // 1: fill a depth-4 cut-through FIFO with the consumer stalled, then release
        for (int i = 1; i <= 4; i++) begin
            send(0, 32'(i), (i == 4), w);
            check("t1_fill_wait", 64'(w), 64'd0);
        end
        idle(0);
        @(negedge clk);
        check("t1_full_tready", 64'(s_tready[0]), 64'd0);
        check("t1_full_level", 64'(level[0]), 64'd4);
        check("t1_full_tvalid", 64'(m_tvalid[0]), 64'd1);
        @(posedge clk);
        #1;
        fix_rdy[0] = 1'b1;
        base = out_cnt[0];
        @(negedge clk);
        check("t1_rd_full_tready", 64'(s_tready[0]), 64'd0);
        check("t1_rd1_tvalid", 64'(m_tvalid[0]), 64'd1);
        @(negedge clk);
        check("t1_after_rd_tready", 64'(s_tready[0]), 64'd1);
        check("t1_after_rd_level", 64'(level[0]), 64'd3);
        check("t1_rd2_tvalid", 64'(m_tvalid[0]), 64'd1);
        repeat (2) begin
            @(negedge clk);
            check("t1_rd_tvalid", 64'(m_tvalid[0]), 64'd1);
        end
        @(negedge clk);
        check("t1_empty_level", 64'(level[0]), 64'd0);
        check("t1_empty_tvalid", 64'(m_tvalid[0]), 64'd0);
        check("t1_count", 64'(out_cnt[0] - base), 64'd4);
        @(posedge clk);
        #1;

        // 2: 20 beats streaming, both sides ready, across pointer wrap
        base = out_cnt[0];
        for (int i = 0; i < 20; i++) begin
            send(0, 32'h100 + 32'(i), (i == 19), w);
            check("t2_wait", 64'(w), 64'd0);
            check("t2_level", 64'(level[0]), 64'd1);
        end
        idle(0);
        drain(0, "t2_drain");
        check("t2_count", 64'(out_cnt[0] - base), 64'd20);

        // 3: packet mode depth 8, 3-beat frame held until tlast
        fix_rdy[1] = 1'b1;
        base = out_cnt[1];
        send(1, 32'hA, 1'b0, w);
        check("t3_a_tvalid", 64'(m_tvalid[1]), 64'd0);
        check("t3_a_pkt", 64'(pkt[1]), 64'd0);
        send(1, 32'hB, 1'b0, w);
        check("t3_b_tvalid", 64'(m_tvalid[1]), 64'd0);
        send(1, 32'hC, 1'b1, w);
        idle(1);
        check("t3_c_tvalid", 64'(m_tvalid[1]), 64'd1);
        check("t3_c_pkt", 64'(pkt[1]), 64'd1);
        repeat (3) begin
            @(negedge clk);
            check("t3_out_tvalid", 64'(m_tvalid[1]), 64'd1);
            check("t3_out_pkt", 64'(pkt[1]), 64'd1);
        end
        @(negedge clk);
        check("t3_end_tvalid", 64'(m_tvalid[1]), 64'd0);
        check("t3_end_pkt", 64'(pkt[1]), 64'd0);
        check("t3_count", 64'(out_cnt[1] - base), 64'd3);
        @(posedge clk);
        #1;

        // 4: packet mode depth 4, 6-beat frame overflows and is forwarded
        fix_rdy[2] = 1'b1;
        base = out_cnt[2];
        for (int i = 1; i <= 4; i++) begin
            send(2, 32'h20 + 32'(i), 1'b0, w);
            check("t4_fill_wait", 64'(w), 64'd0);
            check("t4_fill_tvalid", 64'(m_tvalid[2]), 64'((i == 4) ? 1 : 0));
        end
        check("t4_full_level", 64'(level[2]), 64'd4);
        send(2, 32'h25, 1'b0, w);
        check("t4_b5_wait", 64'(w), 64'd1);
        send(2, 32'h26, 1'b1, w);
        idle(2);
        drain(2, "t4_drain");
        check("t4_count", 64'(out_cnt[2] - base), 64'd6);
        check("t4_pkt", 64'(pkt[2]), 64'd0);
        // forward must be clear: an unterminated beat is held again
        send(2, 32'h77, 1'b0, w);
        idle(2);
        check("t4_hold_tvalid", 64'(m_tvalid[2]), 64'd0);
        repeat (2) begin
            @(negedge clk);
            check("t4_hold_tvalid2", 64'(m_tvalid[2]), 64'd0);
        end
        @(posedge clk);
        #1;
        send(2, 32'h78, 1'b1, w);
        idle(2);
        check("t4_release_tvalid", 64'(m_tvalid[2]), 64'd1);
        drain(2, "t4_drain2");
        check("t4_count2", 64'(out_cnt[2] - base), 64'd8);

        // 5: asynchronous reset mid-frame
        fix_rdy[0] = 1'b0;
        for (int i = 1; i <= 3; i++) send(0, 32'hD0 + 32'(i), 1'b0, w);
        idle(0);
        check("t5_pre_level", 64'(level[0]), 64'd3);
        check("t5_pre_tvalid", 64'(m_tvalid[0]), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_level", 64'(level[0]), 64'd0);
        check("t5_rst_pkt", 64'(pkt[0]), 64'd0);
        check("t5_rst_tvalid", 64'(m_tvalid[0]), 64'd0);
        check("t5_rst_tready", 64'(s_tready[0]), 64'd0);
        fix_rdy[0] = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1 check("t5_rel_tready0", 64'(s_tready[0]), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("t5_rel_tready1", 64'(s_tready[0]), 64'd1);
        repeat (4) begin
            check("t5_no_old_data", 64'(m_tvalid[0]), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        base = out_cnt[0];
        send(0, 32'h55, 1'b1, w);
        idle(0);
        drain(0, "t5_drain");
        check("t5_count", 64'(out_cnt[0] - base), 64'd1);

        // 6: random valid/ready, 1000 beats per instance
        for (int d = 0; d < NDUT; d++) begin
            rnd_rdy[d] = 1'b1;
            base = out_cnt[d];
            rand_stream(d, 1000, (d == 0) ? 5 : 12);
            drain(d, $sformatf("t6_d%0d_drain", d));
            check($sformatf("t6_d%0d_count", d), 64'(out_cnt[d] - base), 64'd1000);
            check($sformatf("t6_d%0d_level", d), 64'(level[d]), 64'd0);
            check($sformatf("t6_d%0d_pkt", d), 64'(pkt[d]), 64'd0);
            rnd_rdy[d] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
